// File: rtl/control_prog_pkg.sv
// Shared types for the programmable controller: opcode encoding, FSM states
// and the instruction-width helper.
package control_prog_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_LD   = 4'h4,
    OP_ST   = 4'h5,
    OP_LDI  = 4'h6,
    OP_OUT  = 4'h7,
    OP_MOV  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_XOR  = 4'hC,
    OP_IN   = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_t;

  // Instruction word is {opcode[3:0], operand[dw-1:0]}.
  function automatic int instr_width(input int dw);
    return 4 + dw;
  endfunction

endpackage

// File: rtl/prog_alu.sv
// Combinational ALU for the two-register accumulator machine. Carry/borrow is
// the top bit of a (DW+1)-bit result; logic ops always produce carry 0.
module prog_alu
  import control_prog_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] y1,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] wide;

  always_comb begin
    wide = '0;
    case (opcode_t'(op))
      OP_ADD:  wide = {1'b0, y} + {1'b0, y1};
      OP_SUB:  wide = {1'b0, y} - {1'b0, y1};
      OP_AND:  wide = {1'b0, y & y1};
      OP_OR:   wide = {1'b0, y | y1};
      OP_XOR:  wide = {1'b0, y ^ y1};
      default: wide = '0;
    endcase
  end

  assign result = wide[DW-1:0];
  assign carry  = wide[DW];
  assign zero   = (wide[DW-1:0] == '0);

endmodule

// File: rtl/control_prog_gen.sv
// Loadable-program accumulator controller: handshaked program loader, fetch/execute
// FSM (two cycles per instruction), data memory, flags and an output port.
module control_prog_gen
  import control_prog_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 5,
  parameter int DMW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_en,
  input  logic          load_valid,
  input  logic [DW+3:0] load_data,
  input  logic          start,
  input  logic [DW-1:0] portin,
  output logic [DW-1:0] portout,
  output logic          out_valid,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc
);

  localparam int IW = instr_width(DW);

  state_t state_reg, state_next;

  logic [AW-1:0] pc_reg;
  logic [IW-1:0] ir_reg;
  logic [DW-1:0] y_reg, y1_reg;
  logic          z_reg, c_reg;
  logic [DW-1:0] portout_reg;
  logic          out_valid_reg;
  logic [AW-1:0] load_ptr_reg;
  logic [DW-1:0] dm_rd_reg;

  logic [IW-1:0] pm [0:(2**AW)-1];
  logic [DW-1:0] dm [0:(2**DMW)-1];

  logic [IW-1:0]  pm_word;
  opcode_t        ir_op;
  logic [DW-1:0]  ir_opd;
  logic [DMW-1:0] ir_dma;
  logic [AW-1:0]  ir_tgt;
  logic [DW-1:0]  alu_result;
  logic           alu_carry, alu_zero;
  logic           pm_we, dm_we;

  assign pm_word = pm[pc_reg];
  assign ir_op   = opcode_t'(ir_reg[IW-1 -: 4]);
  assign ir_opd  = ir_reg[DW-1:0];
  assign ir_dma  = ir_opd[DMW-1:0];
  assign ir_tgt  = ir_opd[AW-1:0];

  prog_alu #(.DW(DW)) u_alu (
    .op     (ir_reg[IW-1 -: 4]),
    .y      (y_reg),
    .y1     (y1_reg),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_HALT: begin
        if (load_en)    state_next = ST_LOAD;
        else if (start) state_next = ST_FETCH;
      end
      ST_LOAD:  if (!load_en) state_next = ST_IDLE;
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC:  state_next = (ir_op == OP_HALT) ? ST_HALT : ST_FETCH;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Gating with reset_n keeps an asserted reset from completing a pending write.
  assign pm_we = reset_n && (state_reg == ST_LOAD) && load_valid;
  assign dm_we = reset_n && (state_reg == ST_EXEC) && (ir_op == OP_ST);

  always_ff @(posedge clk) begin
    if (pm_we) pm[load_ptr_reg] <= load_data;
    if (dm_we) dm[ir_dma] <= y_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg        <= '0;
      ir_reg        <= '0;
      y_reg         <= '0;
      y1_reg        <= '0;
      z_reg         <= 1'b0;
      c_reg         <= 1'b0;
      portout_reg   <= '0;
      out_valid_reg <= 1'b0;
      load_ptr_reg  <= '0;
      dm_rd_reg     <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_HALT: begin
          if (load_en)    load_ptr_reg <= '0;
          else if (start) pc_reg <= '0;
        end
        ST_LOAD: begin
          if (load_valid) load_ptr_reg <= load_ptr_reg + 1'b1;
        end
        ST_FETCH: begin
          ir_reg    <= pm_word;
          // Data memory is read a cycle early so LD sees a registered value in EXEC.
          dm_rd_reg <= dm[pm_word[DMW-1:0]];
          pc_reg    <= pc_reg + 1'b1;
        end
        ST_EXEC: begin
          case (ir_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              y_reg <= alu_result;
              z_reg <= alu_zero;
              c_reg <= alu_carry;
            end
            OP_LD: begin
              y_reg <= dm_rd_reg;
              z_reg <= (dm_rd_reg == '0);
            end
            OP_LDI: begin
              y_reg <= ir_opd;
              z_reg <= (ir_opd == '0);
            end
            OP_IN: begin
              y_reg <= portin;
              z_reg <= (portin == '0);
            end
            OP_OUT: begin
              portout_reg   <= y_reg;
              out_valid_reg <= 1'b1;
            end
            OP_MOV: y1_reg <= y_reg;
            OP_JMP: pc_reg <= ir_tgt;
            OP_JZ:  if (z_reg) pc_reg <= ir_tgt;
            OP_JC:  if (c_reg) pc_reg <= ir_tgt;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign portout   = portout_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg == ST_FETCH) || (state_reg == ST_EXEC);
  assign halted    = (state_reg == ST_HALT);
  assign pc        = pc_reg;

endmodule

// File: doc/control_prog_gen.md
# control_prog_gen

Parametrised successor to the 4-bit program-memory controller. It combines a loadable program memory, an internal data memory, an accumulator pair (Y, Y1) with Z/C flags, and a posedge-only fetch/execute FSM. It adds conditional branches, port input, halt and restart, and a handshaked program loader. It sits between the program-load interface and the external port pins, replacing the fixed 4-bit controller.

## Interface
- DW, 8: data width of Y, Y1, data memory, ports and operand field
- AW, 5: program address width; program memory holds 2^AW instructions; AW ≤ DW
- DMW, 4: data memory address width, 2^DMW words; DMW ≤ DW
- clk  in  1  single clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- load_en  in  1  loader mode request
- load_valid  in  1  load_data is valid this cycle
- load_data  in  4+DW  instruction word {opcode[3:0], operand[DW-1:0]}
- start  in  1  begin execution at PC 0
- portin  in  DW  input port sampled by IN
- portout  out  DW  output port register
- out_valid  out  1  one-cycle pulse when portout updates
- busy  out  1  high in FETCH or EXEC
- halted  out  1  high in HALT
- pc  out  AW  current program counter

## Operation
- States: IDLE, LOAD, FETCH, EXEC, HALT.
- IDLE:
  - load_en=1 → LOAD, and load_ptr clears to 0.
  - start=1 with load_en=0 → FETCH, and PC clears to 0.
  - load_en and start together: load wins.
- LOAD: each cycle with load_valid=1 writes PM[load_ptr] and increments load_ptr, wrapping at 2^AW. load_en=0 → IDLE.
- FETCH: IR ← PM[PC]; PC ← PC+1, wrapping from 2^AW−1 to 0.
- EXEC: performs IR, then → FETCH. HALT goes → HALT instead.
- HALT: start=1 → FETCH with PC=0; load_en=1 → LOAD.
- load_en and start are ignored in FETCH and EXEC.
- Opcodes (imm = operand, a = operand[DMW-1:0], t = operand[AW-1:0]):
  - 0 ADD: Y ← Y+Y1; C ← carry
  - 1 SUB: Y ← Y−Y1; C ← borrow
  - 2 AND, 3 OR, C XOR: Y ← Y op Y1; C ← 0
  - 4 LD: Y ← DM[a]
  - 5 ST: DM[a] ← Y
  - 6 LDI: Y ← imm
  - 7 OUT: portout ← Y; out_valid pulse
  - 8 MOV: Y1 ← Y
  - 9 JMP: PC ← t
  - A JZ: PC ← t if Z
  - B JC: PC ← t if C
  - D IN: Y ← portin
  - E NOP
  - F HALT
- Flags:
  - Z ← (new Y == 0) on every opcode that writes Y (ADD, SUB, AND, OR, XOR, LD, LDI, IN).
  - C is written only by the ALU ops.
  - All other opcodes leave both flags unchanged.
- Arithmetic is modulo 2^DW; the carry/borrow is bit DW of a (DW+1)-bit sum.
- Reset: the following go to 0 and the FSM goes to IDLE: portout, out_valid, halted, busy, pc, Y, Y1, Z, C, IR, load_ptr. PM and DM contents are not reset and survive a reset.

## Timing
- Every instruction takes exactly 2 cycles (FETCH, EXEC); memory read is synchronous in FETCH/EXEC.
- start sampled at edge k:
  - instruction i's register effects are visible after edge k+2+2i;
  - OUT sets out_valid high for the cycle following that edge.
- Taken jump: the next FETCH reads PM[t]; there is no delay slot. Not-taken falls through to PC+1.
- LD immediately after ST to the same address returns the stored value.
- busy=1 exactly in FETCH/EXEC; halted=1 exactly in HALT; pc reflects the register continuously.
- reset_n low at any point, including mid-EXEC, aborts the instruction with no partial write to DM or portout.

## Structure
- Package control_prog_pkg holds:
  - opcode enum (4-bit) and FSM state enum;
  - localparam function giving instruction width 4+DW.
- Sub-module prog_alu (combinational):
  - inputs: op, Y, Y1
  - outputs: result, carry, zero
- PM and DM are inferred arrays inside control_prog_gen.

## Test plan
All scenarios use DW=8, AW=5, DMW=4.
- Load LDI 5, MOV, LDI 3, ADD, OUT, HALT; start at edge k → portout=8 with out_valid after edge k+10; halted=1 after k+12; Z=0, C=0.
- LDI FF, MOV, LDI 01, ADD, JC 7, OUT, HALT, OUT, HALT → Y=0, Z=1, C=1; jump taken; single out_valid with portout=00 from PM[7].
- LDI A5, ST 3, LDI 0, IN (portin=3C), LD 3, OUT → portout=A5; Z=0 after LDI 0 → IN → LD sequence, Z=1 only after LDI 0.
- 32 NOPs loaded: load_ptr wraps to 0 after word 31; run → pc goes 31→0 and keeps cycling; busy stays 1.
- reset_n low during EXEC of ST → DM unchanged, all outputs 0, IDLE; start → same program reruns with identical results (PM retained).
- load_en and load_valid pulsed during run → PM unchanged, no state change; load_en+start in IDLE → LOAD entered, no execution.
